spi_slave_sync: RTL and testbench

SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

---
 rtl/spi_slave_sync_if.sv | 40 ++++
 rtl/spi_slave_sync.sv | 169 ++++++++++++++++
 tb/tb_spi_slave_sync.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_sync_if.sv
// SPI slave pin and parallel-word bundle shared by the slave core and its integrator.
// No latency or storage; pure signal grouping.
// No backpressure: words are presented and consumed at frame rate.
interface spi_slave_sync_if #(
   parameter int WIDTH = 8
);
   logic             CS;
   logic             SCLK;
   logic             MOSI;
   logic             MISO;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             rx_valid;
   logic             busy;
   logic             abort;

   modport slave (
      input  CS,
      input  SCLK,
      input  MOSI,
      input  data_in,
      output MISO,
      output data_out,
      output rx_valid,
      output busy,
      output abort
   );

   modport master (
      output CS,
      output SCLK,
      output MOSI,
      output data_in,
      input  MISO,
      input  data_out,
      input  rx_valid,
      input  busy,
      input  abort
   );
endinterface

// File: rtl/spi_slave_sync.sv
// SPI mode-0 slave, MSB first, oversampled by clk through SYNC_STAGES-deep synchronizers.
// Latency: SYNC_STAGES+1 clk from a pin edge to its effect on MISO/data_out/rx_valid.
// No backpressure: data_out is overwritten at each completed frame, data_in is sampled at frame start/boundary.
module spi_slave_sync #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input logic             clk,
   input logic             rst,
   spi_slave_sync_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'b01,
      SHIFT = 2'b10
   } state_t;

   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   cs_d;
   logic                   sclk_d;
   logic [SYNC_STAGES:0]   flush_sr;
   logic                   cs_armed;

   logic cs_s;
   logic sclk_s;
   logic mosi_s;
   logic cs_fall;
   logic cs_rise;
   logic sclk_rise;
   logic sclk_fall;

   state_t           state_q,    state_n;
   logic [CW-1:0]    cnt_q,      cnt_n;
   logic [WIDTH-1:0] tx_q,       tx_n;
   logic [WIDTH-1:0] rx_q,       rx_n;
   logic             miso_q,     miso_n;
   logic [WIDTH-1:0] dout_q,     dout_n;
   logic             rx_valid_q, rx_valid_n;
   logic             abort_q,    abort_n;

   logic [WIDTH-1:0] tx_shifted;
   logic [WIDTH-1:0] rx_shifted;

   assign cs_s   = cs_sync[SYNC_STAGES-1];
   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // CS resets to the inactive level, so a low CS at reset release would look like a
   // falling edge; frames are only armed once the flushed synchronizer has seen CS high.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cs_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_d      <= 1'b1;
         sclk_d    <= 1'b0;
         flush_sr  <= '0;
         cs_armed  <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.CS};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
         cs_d      <= cs_s;
         sclk_d    <= sclk_s;
         flush_sr  <= {flush_sr[SYNC_STAGES-1:0], 1'b1};
         cs_armed  <= cs_armed | (flush_sr[SYNC_STAGES] & cs_s & cs_d);
      end
   end

   assign cs_fall   = cs_armed & cs_d & ~cs_s;
   assign cs_rise   = ~cs_d & cs_s;
   assign sclk_rise = ~sclk_d & sclk_s;
   assign sclk_fall = sclk_d & ~sclk_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         miso_q     <= 1'b0;
         dout_q     <= '0;
         rx_valid_q <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_n;
         cnt_q      <= cnt_n;
         tx_q       <= tx_n;
         rx_q       <= rx_n;
         miso_q     <= miso_n;
         dout_q     <= dout_n;
         rx_valid_q <= rx_valid_n;
         abort_q    <= abort_n;
      end
   end

   always_comb begin
      state_n    = state_q;
      cnt_n      = cnt_q;
      tx_n       = tx_q;
      rx_n       = rx_q;
      miso_n     = miso_q;
      dout_n     = dout_q;
      rx_valid_n = 1'b0;
      abort_n    = 1'b0;

      tx_shifted    = tx_q << 1;
      rx_shifted    = rx_q << 1;
      rx_shifted[0] = mosi_s;

      case (state_q)
         IDLE: begin
            miso_n = 1'b0;
            cnt_n  = '0;
            if (cs_fall) begin
               state_n = SHIFT;
               tx_n    = bus.data_in;
               rx_n    = '0;
               miso_n  = bus.data_in[WIDTH-1];
            end
         end

         SHIFT: begin
            // CS release wins over a coincident SCLK edge.
            if (cs_rise) begin
               state_n = IDLE;
               miso_n  = 1'b0;
               cnt_n   = '0;
               abort_n = (cnt_q != '0);
            end else if (sclk_rise) begin
               rx_n = rx_shifted;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  dout_n     = rx_shifted;
                  rx_valid_n = 1'b1;
                  cnt_n      = '0;
                  tx_n       = bus.data_in;
               end else begin
                  cnt_n = cnt_q + CW'(1);
               end
            end else if (sclk_fall) begin
               // At a frame boundary the freshly reloaded word is presented unshifted.
               if (cnt_q == '0) begin
                  miso_n = tx_q[WIDTH-1];
               end else begin
                  tx_n   = tx_shifted;
                  miso_n = tx_shifted[WIDTH-1];
               end
            end
         end

         default: begin
            state_n = IDLE;
            miso_n  = 1'b0;
            cnt_n   = '0;
         end
      endcase
   end

   assign bus.MISO     = miso_q;
   assign bus.data_out = dout_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.abort    = abort_q;
   assign bus.busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_slave_sync.sv
// Randomized scoreboard bench for spi_slave_sync: a master model drives frames and queues
// the expected rx_valid/abort events; an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_spi_slave_sync;

   typedef struct {
      bit         is_abort;
      logic [7:0] word;
   } exp_t;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   exp_t       sb[$];
   exp_t       mon_e;
   logic [7:0] model_last;
   logic [7:0] tx_w  [0:3];
   logic [7:0] din_w [0:3];

   spi_slave_sync_if #(.WIDTH(8)) bus ();

   spi_slave_sync #(
      .WIDTH       (8),
      .SYNC_STAGES (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, summary not reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Every rx_valid/abort pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (bus.rx_valid || bus.abort) begin
         check("pulse_exclusive", {31'b0, bus.rx_valid & bus.abort}, 32'd0);
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pulse: got rx_valid=%0b abort=%0b expected no pulse",
                     bus.rx_valid, bus.abort);
         end else begin
            mon_e = sb.pop_front();
            check("pulse_kind_abort", {31'b0, bus.abort}, {31'b0, mon_e.is_abort});
            check("data_out", {24'b0, bus.data_out}, {24'b0, mon_e.word});
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"},     {31'b0, bus.MISO},     32'd0);
      check({tag, "_data_out"}, {24'b0, bus.data_out}, 32'd0);
      check({tag, "_rx_valid"}, {31'b0, bus.rx_valid}, 32'd0);
      check({tag, "_busy"},     {31'b0, bus.busy},     32'd0);
      check({tag, "_abort"},    {31'b0, bus.abort},    32'd0);
   endtask

   // Master model: nbits bits under one CS assertion; bit b belongs to frame b/8.
   // The slave must return din_w[f] MSB first, and each completed frame yields tx_w[f].
   task automatic xfer(input int nbits, input int hmin, input int hmax, input bit rst_end);
      int f;
      int i;
      bus.data_in = din_w[0];
      clks(2);
      bus.CS   = 1'b0;
      bus.MOSI = tx_w[0][7];
      clks(hmin + $urandom_range(hmax - hmin));
      for (int b = 0; b < nbits; b++) begin
         f = b / 8;
         i = 7 - (b % 8);
         bus.SCLK = 1'b1;
         check("busy_in_frame", {31'b0, bus.busy}, 32'd1);
         check($sformatf("miso_f%0d_b%0d", f, 7 - i), {31'b0, bus.MISO}, {31'b0, din_w[f][i]});
         if (i == 0) begin
            sb.push_back('{1'b0, tx_w[f]});
            model_last = tx_w[f];
         end
         if ((b % 8) == 3) bus.data_in = din_w[f + 1];
         clks(hmin + $urandom_range(hmax - hmin));
         bus.SCLK = 1'b0;
         if (b + 1 < nbits) bus.MOSI = tx_w[(b + 1) / 8][7 - ((b + 1) % 8)];
         clks(hmin + $urandom_range(hmax - hmin));
      end
      if (rst_end) begin
         rst = 1'b0;
         #1;
         check_reset_outputs("midreset");
         clks(3);
         bus.CS   = 1'b1;
         bus.SCLK = 1'b0;
         clks(3);
         rst = 1'b1;
         model_last = 8'h00;
         clks(8);
      end else begin
         bus.CS = 1'b1;
         if ((nbits % 8) != 0) sb.push_back('{1'b1, model_last});
         clks(6);
         check("busy_after_cs", {31'b0, bus.busy}, 32'd0);
         check("miso_after_cs", {31'b0, bus.MISO}, 32'd0);
      end
   endtask

   task automatic randomize_words();
      for (int k = 0; k < 4; k++) begin
         tx_w[k]  = 8'($urandom);
         din_w[k] = 8'($urandom);
      end
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      model_last  = 8'h00;
      rst         = 1'b0;
      bus.CS      = 1'b1;
      bus.SCLK    = 1'b0;
      bus.MOSI    = 1'b0;
      bus.data_in = 8'h00;
      for (int k = 0; k < 4; k++) begin
         tx_w[k]  = 8'h00;
         din_w[k] = 8'h00;
      end
      clks(3);
      check_reset_outputs("reset");
      rst = 1'b1;
      clks(8);

      // Single frame: slave sends 0xCC, master sends 0xAA.
      tx_w[0] = 8'hAA; din_w[0] = 8'hCC; din_w[1] = 8'h00;
      xfer(8, 3, 5, 1'b0);

      // Back-to-back frames under continuous CS.
      tx_w[0] = 8'h3C; tx_w[1] = 8'hA5;
      din_w[0] = 8'h0F; din_w[1] = 8'hF0; din_w[2] = 8'h00;
      xfer(16, 3, 5, 1'b0);

      // Abort after 3 bits; data_out must still hold 0xA5.
      tx_w[0] = 8'($urandom); din_w[0] = 8'($urandom); din_w[1] = 8'($urandom);
      xfer(3, 3, 5, 1'b0);
      check("data_out_after_abort", {24'b0, bus.data_out}, {24'b0, model_last});

      // Reset after 5 bits, then a clean 0x5A frame.
      randomize_words();
      xfer(5, 3, 4, 1'b1);
      tx_w[0] = 8'h5A; din_w[0] = 8'($urandom);
      xfer(8, 3, 5, 1'b0);

      // Reset released with CS already low must not start a frame.
      rst = 1'b0;
      clks(2);
      bus.CS = 1'b0;
      clks(2);
      rst = 1'b1;
      model_last = 8'h00;
      clks(20);
      check("no_frame_cs_low_at_release", {31'b0, bus.busy}, 32'd0);
      bus.CS = 1'b1;
      clks(10);
      check("idle_after_cs_high", {31'b0, bus.busy}, 32'd0);

      // SCLK noise with CS high.
      for (int k = 0; k < 10; k++) begin
         bus.SCLK = 1'b1;
         bus.MOSI = 1'($urandom);
         clks(3);
         bus.SCLK = 1'b0;
         clks(3);
         check("noise_busy", {31'b0, bus.busy}, 32'd0);
         check("noise_miso", {31'b0, bus.MISO}, 32'd0);
      end

      // Minimum SCLK phase timing, 100 frames.
      for (int k = 0; k < 100; k++) begin
         randomize_words();
         xfer(8, 3, 3, 1'b0);
      end

      // Random lengths (aborts and back-to-back) with random phase lengths.
      for (int k = 0; k < 30; k++) begin
         randomize_words();
         xfer($urandom_range(16, 1), 3, 6, 1'b0);
      end

      clks(10);
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
